ysyx_040750_ex_ctrl: RTL and testbench

YSYX_040750_EX_CTRL -- requirements
Module: ysyx_040750_ex_ctrl

---
 rtl/ysyx_040750_ex_ctrl.sv | 108 ++++++++++
 tb/tb_ysyx_040750_ex_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ysyx_040750_ex_ctrl.sv
// EX-stage control: single-cycle pass-through, multicycle ALU sequencing,
// MEM back-pressure hold, flush/kill handling, watchdog and CALC perf count.
module ysyx_040750_ex_ctrl #(
    parameter logic [7:0] TIMEOUT = 8'd80
) (
    input  logic        I_sys_clk,
    input  logic        I_rst,
    input  logic        I_ID_EX_valid,
    input  logic        I_multicycle,
    input  logic        I_alu_result_valid,
    input  logic        I_EX_MEM_ready,
    input  logic        I_flush,
    output logic        O_EX_ready,
    output logic        O_EX_valid,
    output logic        O_alu_start,
    output logic        O_alu_kill,
    output logic        O_busy,
    output logic        O_timeout,
    output logic [31:0] O_calc_cycles
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  wdog_q, wdog_d;
    logic        timeout_q, timeout_d;
    logic [31:0] calc_q, calc_d;
    logic        accept;

    always_ff @(posedge I_sys_clk or posedge I_rst) begin
        if (I_rst) begin
            state_q   <= S_IDLE;
            wdog_q    <= 8'd0;
            timeout_q <= 1'b0;
            calc_q    <= 32'd0;
        end else begin
            state_q   <= state_d;
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
            calc_q    <= calc_d;
        end
    end

    // Handshake outputs are gated by reset so nothing leaks while it is held.
    always_comb begin
        state_d     = state_q;
        wdog_d      = wdog_q;
        timeout_d   = timeout_q;
        calc_d      = calc_q;
        accept      = 1'b0;
        O_EX_ready  = 1'b0;
        O_EX_valid  = 1'b0;
        O_alu_start = 1'b0;
        O_alu_kill  = 1'b0;
        O_busy      = 1'b0;
        if (!I_rst) begin
            O_busy     = (state_q != S_IDLE);
            O_EX_ready = (state_q == S_IDLE) & I_EX_MEM_ready & ~I_flush;
            accept     = I_ID_EX_valid & O_EX_ready;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (I_multicycle) begin
                            O_alu_start = 1'b1;
                            wdog_d      = 8'd0;
                            state_d     = S_CALC;
                        end else begin
                            O_EX_valid = 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    calc_d = calc_q + 32'd1;
                    wdog_d = (wdog_q == 8'hFF) ? wdog_q : wdog_q + 8'd1;
                    if (wdog_d == TIMEOUT) begin
                        timeout_d = 1'b1;
                    end
                    if (I_flush) begin
                        O_alu_kill = 1'b1;
                        state_d    = S_IDLE;
                    end else if (I_alu_result_valid) begin
                        O_EX_valid = 1'b1;
                        state_d    = I_EX_MEM_ready ? S_IDLE : S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (I_flush) begin
                        state_d = S_IDLE;
                    end else begin
                        O_EX_valid = 1'b1;
                        if (I_EX_MEM_ready) begin
                            state_d = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign O_timeout     = timeout_q;
    assign O_calc_cycles = calc_q;

endmodule

// File: tb/tb_ysyx_040750_ex_ctrl.sv
// Randomized bench for ysyx_040750_ex_ctrl against a transaction-level model
// that tracks "op in flight" and "result waiting for MEM".
module tb_ysyx_040750_ex_ctrl;

    localparam logic [7:0] TO = 8'd4;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, multi, res_valid, mem_ready, flush;
    logic        ex_ready, ex_valid, alu_start, alu_kill, busy, tmo_o;
    logic [31:0] calc_cycles;

    always #5 clk = ~clk;

    ysyx_040750_ex_ctrl #(.TIMEOUT(TO)) dut (
        .I_sys_clk         (clk),
        .I_rst             (rst),
        .I_ID_EX_valid     (id_valid),
        .I_multicycle      (multi),
        .I_alu_result_valid(res_valid),
        .I_EX_MEM_ready    (mem_ready),
        .I_flush           (flush),
        .O_EX_ready        (ex_ready),
        .O_EX_valid        (ex_valid),
        .O_alu_start       (alu_start),
        .O_alu_kill        (alu_kill),
        .O_busy            (busy),
        .O_timeout         (tmo_o),
        .O_calc_cycles     (calc_cycles)
    );

    int total = 0;
    int bad   = 0;

    // model: pending = multicycle op waiting on ALU, have = result waiting on MEM
    bit          pend, have, m_tmo;
    int          wd;
    logic [31:0] cc;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        pend  = 0;
        have  = 0;
        m_tmo = 0;
        wd    = 0;
        cc    = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ready"}, 32'(ex_ready), 0);
        chk({tag, "_valid"}, 32'(ex_valid), 0);
        chk({tag, "_start"}, 32'(alu_start), 0);
        chk({tag, "_kill"}, 32'(alu_kill), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_tmo"}, 32'(tmo_o), 0);
        chk({tag, "_calc"}, calc_cycles, 0);
    endtask

    task automatic cyc(input bit v, input bit mc, input bit rv,
                       input bit mr, input bit fl);
        bit bsy, er, acc, ev;
        @(negedge clk);
        id_valid  = v;
        multi     = mc;
        res_valid = rv;
        mem_ready = mr;
        flush     = fl;
        #1;
        bsy = pend || have;
        er  = !bsy && mr && !fl;
        acc = v && er;
        ev  = !fl && ((acc && !mc) || (pend && rv) || have);
        chk("ready", 32'(ex_ready), 32'(er));
        chk("valid", 32'(ex_valid), 32'(ev));
        chk("start", 32'(alu_start), 32'(acc && mc));
        chk("kill", 32'(alu_kill), 32'(fl && pend));
        chk("busy", 32'(busy), 32'(bsy));
        chk("tmo", 32'(tmo_o), 32'(m_tmo));
        chk("calc", calc_cycles, cc);
        if (pend) begin
            cc = cc + 1;
            if (wd < 255) wd++;
            if (wd == int'(TO)) m_tmo = 1;
        end
        if (fl) begin
            pend = 0;
            have = 0;
        end else if (acc && mc) begin
            pend = 1;
            wd   = 0;
        end else if (pend && rv) begin
            pend = 0;
            have = !mr;
        end else if (have && mr) begin
            have = 0;
        end
    endtask

    // reset asserted between clock edges; outputs must clear before next edge
    task automatic async_reset(input string tag);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_zero(tag);
        model_clear();
        @(negedge clk);
        id_valid  = 0;
        multi     = 0;
        res_valid = 0;
        mem_ready = 0;
        flush     = 0;
        rst       = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        id_valid  = 0;
        multi     = 0;
        res_valid = 0;
        mem_ready = 1;
        flush     = 0;
        model_clear();
        #3 chk_zero("rst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // single-cycle op
        cyc(1, 0, 0, 1, 0);
        cyc(1, 0, 0, 1, 0);

        // multicycle op, result 5 cycles after accept
        cyc(1, 1, 0, 1, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 1, 1, 0);
        @(posedge clk);
        #1 chk("calc5", calc_cycles, 32'd5);
        cyc(0, 0, 0, 1, 0);

        // MEM stall into HOLD
        cyc(1, 1, 0, 1, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);

        // flush in CALC together with result and a new valid
        cyc(1, 1, 0, 1, 0);
        cyc(1, 1, 1, 1, 1);
        cyc(0, 0, 0, 1, 0);

        // watchdog: result never arrives
        async_reset("rst2");
        cyc(1, 1, 0, 1, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0);
        @(posedge clk);
        #1 chk("tmo_set", 32'(tmo_o), 32'd1);
        cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 0, 1, 0);
        chk("tmo_sticky", 32'(tmo_o), 32'd1);

        // async reset mid-HOLD
        cyc(1, 1, 0, 1, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        async_reset("rst_hold");
        cyc(0, 0, 0, 1, 0);

        // random traffic
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                async_reset("rst_rnd");
            end else begin
                cyc($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 7,
                    $urandom_range(0, 99) < 6);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
